// File: rtl/bird_datapath.sv
// Bird vertical-position datapath: per-frame position update, status back to the
// control FSM, and an erase-then-draw pixel scan for the VGA plotter.
module bird_datapath #(
  parameter int unsigned X_POS       = 20,
  parameter int unsigned START_Y     = 56,
  parameter int unsigned SIZE        = 4,
  parameter int unsigned GROUND_Y    = 116,
  parameter int unsigned RISE_STEP   = 2,
  parameter int unsigned FALL_STEP   = 1,
  parameter int unsigned RISE_FRAMES = 8,
  parameter logic [2:0]  BIRD_COL    = 3'b110,
  parameter logic [2:0]  BG_COL      = 3'b011
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [3:0] state_in,
  output logic       flag,
  output logic       touched,
  output logic [6:0] bird_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int unsigned CW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned XW    = 8;
  localparam int unsigned YW    = 7;
  localparam int unsigned RW    = 4;
  localparam int unsigned LOW_Y = GROUND_Y - SIZE;

  localparam logic [3:0] C_START   = 4'd0;
  localparam logic [3:0] C_RAISING = 4'd1;
  localparam logic [3:0] C_FALLING = 4'd2;
  localparam logic [3:0] C_STOP    = 4'd3;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

  state_t          state, state_nxt;
  logic [3:0]      last_ctrl;
  logic [RW-1:0]   rise_cnt;
  logic [YW-1:0]   old_y;
  logic [CW-1:0]   cx, cy;

  logic            take_frame;
  logic            scan_last;
  logic [CW-1:0]   cx_adv, cy_adv;
  logic [7:0]      y_ext, rise_y, fall_y;
  logic [YW-1:0]   y_upd;

  logic            plot_nxt, busy_nxt, emit;
  logic [CW-1:0]   cx_nxt, cy_nxt;
  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y_nxt, base_y;
  logic [2:0]      col_nxt;

  assign take_frame = (state == S_IDLE) && frame_tick;
  assign flag       = (32'(rise_cnt) >= RISE_FRAMES) || (bird_y == '0);
  assign touched    = (bird_y == YW'(LOW_Y));

  // Scan counter helpers: cx runs fastest, cy steps when cx wraps
  always_comb begin
    scan_last = (cx == CW'(SIZE - 1)) && (cy == CW'(SIZE - 1));
    cx_adv    = cx + CW'(1);
    cy_adv    = cy;
    if (cx == CW'(SIZE - 1)) begin
      cx_adv = '0;
      cy_adv = cy + CW'(1);
    end
  end

  // Next bird position, computed at 8 bits so a rise cannot wrap below row 0
  always_comb begin
    y_ext  = {1'b0, bird_y};
    rise_y = (y_ext > 8'(RISE_STEP)) ? (y_ext - 8'(RISE_STEP)) : 8'd0;
    fall_y = y_ext + 8'(FALL_STEP);
    if (fall_y > 8'(LOW_Y)) fall_y = 8'(LOW_Y);
    case (last_ctrl)
      C_START:   y_upd = YW'(START_Y);
      C_RAISING: y_upd = YW'(rise_y);
      C_FALLING: y_upd = YW'(fall_y);
      C_STOP:    y_upd = bird_y;
      default:   y_upd = bird_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (frame_tick) state_nxt = S_ERASE;
      S_ERASE: if (scan_last)  state_nxt = S_DRAW;
      S_DRAW:  if (scan_last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered plot outputs describe the pixel for the coming cycle
  always_comb begin
    plot_nxt = 1'b0;
    busy_nxt = 1'b0;
    emit     = 1'b0;
    cx_nxt   = cx;
    cy_nxt   = cy;
    x_nxt    = x_out;
    y_nxt    = y_out;
    col_nxt  = colour;
    base_y   = bird_y;
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          cx_nxt  = '0;
          cy_nxt  = '0;
          emit    = 1'b1;
          base_y  = bird_y;
          col_nxt = BG_COL;
        end
      end
      S_ERASE: begin
        emit = 1'b1;
        if (scan_last) begin
          cx_nxt  = '0;
          cy_nxt  = '0;
          base_y  = bird_y;
          col_nxt = BIRD_COL;
        end else begin
          cx_nxt  = cx_adv;
          cy_nxt  = cy_adv;
          base_y  = old_y;
          col_nxt = BG_COL;
        end
      end
      S_DRAW: begin
        if (scan_last) begin
          cx_nxt = '0;
          cy_nxt = '0;
        end else begin
          emit    = 1'b1;
          cx_nxt  = cx_adv;
          cy_nxt  = cy_adv;
          base_y  = bird_y;
          col_nxt = BIRD_COL;
        end
      end
      default: ;
    endcase
    if (emit) begin
      plot_nxt = 1'b1;
      busy_nxt = 1'b1;
      x_nxt    = XW'(X_POS) + XW'(cx_nxt);
      y_nxt    = base_y + YW'(cy_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_ctrl <= C_START;
      rise_cnt  <= '0;
      bird_y    <= YW'(START_Y);
      old_y     <= '0;
      cx        <= '0;
      cy        <= '0;
      x_out     <= '0;
      y_out     <= '0;
      colour    <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (state_in <= C_STOP) last_ctrl <= state_in;
      if (last_ctrl != C_RAISING)                    rise_cnt <= '0;
      else if (take_frame && (rise_cnt != '1))       rise_cnt <= rise_cnt + RW'(1);
      if (take_frame) begin
        old_y  <= bird_y;
        bird_y <= y_upd;
      end
      cx     <= cx_nxt;
      cy     <= cy_nxt;
      x_out  <= x_nxt;
      y_out  <= y_nxt;
      colour <= col_nxt;
      plot   <= plot_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: doc/bird_datapath.md
# bird_datapath

Datapath stage directly downstream of the bird control FSM. It consumes the 4-bit control state code, advances the bird's vertical position once per frame tick, and returns the `flag` (rise finished / ceiling) and `touched` (ground hit) status inputs to the FSM. It also drives the VGA plotter: each frame it erases the old bird square and draws the new one, one pixel per clock.

## Interface
Parameters:
- `X_POS`, 20: fixed left column of the bird square.
- `START_Y`, 56: top row of the bird after reset and in START.
- `SIZE`, 4: edge length of the square in pixels. Must be a power of two, ≤ 8.
- `GROUND_Y`, 116: first row of ground. The lowest legal bird top is `GROUND_Y-SIZE`.
- `RISE_STEP`, 2: rows moved up per frame while RAISING.
- `FALL_STEP`, 1: rows moved down per frame while FALLING.
- `RISE_FRAMES`, 8: number of RAISING frames before `flag` asserts.
- `BIRD_COL`, 3'b110: bird colour.
- `BG_COL`, 3'b011: background colour used for erase.

Ports:
- `clk`, in, 1: system clock.
- `resetn`, in, 1: synchronous, active-low reset. One clock domain only; reset is sampled on the rising edge of `clk`.
- `frame_tick`, in, 1: single-cycle pulse, one per frame.
- `state_in`, in, 4: FSM state code. 0 = START, 1 = RAISING, 2 = FALLING, 3 = STOP, 4 = DRAW.
- `flag`, out, 1: bird has risen long enough, or is at row 0.
- `touched`, out, 1: bird is resting on the ground.
- `bird_y`, out, 7: current top row of the bird.
- `x_out`, out, 8: plot column.
- `y_out`, out, 7: plot row.
- `colour`, out, 3: plot colour.
- `plot`, out, 1: pixel write strobe.
- `busy`, out, 1: erase/draw sequence in progress.

## Operation
- Control-state capture: register `last_ctrl` loads `state_in` every clock where `state_in` ∈ {0..3}. DRAW (4) and undefined codes leave it unchanged. Reset value of `last_ctrl` is START.
- Rise counter `rise_cnt` (4 bits, saturating at 15):
  - cleared every clock where `last_ctrl` ≠ RAISING;
  - incremented on each frame update taken while `last_ctrl` is RAISING.
- Status outputs (combinational from registers):
  - `flag = (rise_cnt >= RISE_FRAMES) || (bird_y == 0)`
  - `touched = (bird_y == GROUND_Y-SIZE)`
- Plot FSM states are IDLE, ERASE and DRAW.
  - IDLE + `frame_tick`: latch `old_y = bird_y`, apply the position update below, then go to ERASE.
  - START: `bird_y = START_Y`.
  - RAISING: `bird_y = max(bird_y-RISE_STEP, 0)`. Compute at 8 bits; no underflow wrap.
  - FALLING: `bird_y = min(bird_y+FALL_STEP, GROUND_Y-SIZE)`.
  - STOP: hold.
  - ERASE: SIZE² cycles. Each cycle plots `BG_COL` at (`X_POS+cx`, `old_y+cy`). `cx` runs fastest from 0 to SIZE-1, then `cy` increments. After the last pixel (cx = cy = SIZE-1), clear the counters and go to DRAW.
  - DRAW: same scan at (`X_POS+cx`, `bird_y+cy`) with `BIRD_COL`. After the last pixel, go to IDLE.
- `frame_tick` is ignored while in ERASE or DRAW. There is no queuing.
- Erase and draw run even when `bird_y == old_y`.

## Timing
- Reset values: `bird_y = START_Y`, `rise_cnt = 0`, FSM in IDLE, `plot = 0`, `busy = 0`, `x_out = 0`, `y_out = 0`, `colour = 0`, `flag = 0`, `touched = 0`.
- Plot outputs are registered. With the tick in cycle t:
  - `bird_y` holds the new value from t+1.
  - `plot` and `busy` are high for cycles t+1 … t+2·SIZE². With defaults that is t+1 … t+32.
  - ERASE pixels appear t+1 … t+16; DRAW pixels appear t+17 … t+32.
  - IDLE is re-entered at t+33, and a tick in that cycle is accepted.
- `flag` and `touched` follow `bird_y`/`rise_cnt` in the same cycle those registers update.
- Reset asserted mid-sequence: on the next edge, all outputs take their reset values. The partial square is left on screen.
- If `state_in` changes during ERASE/DRAW, `last_ctrl` still updates. It only affects the next frame's position update.

## Test plan
- Reset, then a tick with `state_in` = START → 32 plot pulses; first erase pixel at (20, 56), first draw pixel at (20, 56); `busy` falls at t+33.
- `last_ctrl` = RAISING from `bird_y` = 56, 8 ticks → `bird_y` = 40; `flag` rises after the 8th update. Switching to FALLING clears `flag` the next clock.
- RAISING from `bird_y` = 1 → `bird_y` = 0 (no wrap to 127); `flag` = 1.
- FALLING from 110, 10 ticks → saturates at 112; `touched` = 1. STOP holds 112. START restores 56 and drops `touched`.
- Tick at t+5 of a sequence → ignored; exactly 32 plot pulses. A tick at t+33 starts a new sequence.
- `resetn` low at t+10 → `plot`, `busy` = 0 next cycle; `bird_y` = 56; FSM in IDLE.
